// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with shadowed display data.
// Latency: load visible on pins one clock after capture; all outputs registered (1 cycle after cnt/idx/shadow).
// Backpressure: none; free-running scan, load accepted on any cycle.
//
// Ports:
//   clk, rst      single clock domain, asynchronous active-high reset
//   value_in      packed hex nibbles, nibble i = bits [4i+3:4i], digit 0 least significant
//   load          capture value_in/dp_in/digit_en/lz_blank into the shadow registers
//   dp_in         per-digit decimal point request
//   digit_en      per-digit enable (0 keeps the digit dark)
//   lz_blank      leading-zero suppression enable
//   seg_out       segment drive, bit 6 = a ... bit 0 = g
//   dp_out        decimal point drive
//   an_out        anode select, one-hot when lit, all off otherwise
//   slot_strobe   one-cycle pulse when the digit index advances
//
// Legal parameters: NUM_DIGITS 1..8, SCAN_DIV >= 2, 0 <= GUARD < SCAN_DIV.
// ACTIVE_LOW=1 inverts seg_out, dp_out and an_out at the pins.

module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    slot_strobe
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(SCAN_DIV);
  // A single-digit display still needs a 1-bit index register.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Pin polarity: XOR mask applied to the active-high internal form.
  localparam logic                  POL     = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

  // ---------------------------------------------------------------------------
  // Segment map, active-high, bit 6 = a ... bit 0 = g
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_map(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h1F;
      4'hC:    s = 7'h4E;
      4'hD:    s = 7'h3D;
      4'hE:    s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;
  logic [4*NUM_DIGITS-1:0] value_q,  value_d;
  logic [NUM_DIGITS-1:0]   dp_q,     dp_d;
  logic [NUM_DIGITS-1:0]   en_q,     en_d;
  logic                    lzb_q,    lzb_d;

  logic [6:0]              seg_q,    seg_d;
  logic                    dpo_q,    dpo_d;
  logic [NUM_DIGITS-1:0]   an_q,     an_d;
  logic                    strobe_q, strobe_d;

  // ---------------------------------------------------------------------------
  // Scan counter and digit index
  // ---------------------------------------------------------------------------
  logic cnt_wrap;

  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow registers: only load updates them
  // ---------------------------------------------------------------------------
  always_comb begin
    value_d = value_q;
    dp_d    = dp_q;
    en_d    = en_q;
    lzb_d   = lzb_q;
    if (load) begin
      value_d = value_in;
      dp_d    = dp_in;
      en_d    = digit_en;
      lzb_d   = lz_blank;
    end
  end

  // ---------------------------------------------------------------------------
  // Anti-ghosting guard: anodes stay off for the first GUARD cycles of a slot.
  // With GUARD=0 there is no guard window at all.
  // ---------------------------------------------------------------------------
  logic in_guard;

  if (GUARD > 0) begin : g_guard
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
    assign in_guard = (cnt_q < GUARD_CNT);
  end else begin : g_no_guard
    assign in_guard = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Leading-zero suppression: digit i is dark when it and every digit above it
  // are zero. Digit 0 is exempt so a zero value still shows one "0".
  // ---------------------------------------------------------------------------
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] supp;

  always_comb begin
    zero_above = 1'b1;
    supp       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (value_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        supp[i] = lzb_q && zero_above;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Current-digit select: decode idx into nibble, dp, enable and anode bit
  // ---------------------------------------------------------------------------
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_supp;
  logic [NUM_DIGITS-1:0] an_sel;

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_en   = 1'b0;
    cur_supp = 1'b0;
    an_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = value_q[4*i +: 4];
        cur_dp    = dp_q[i];
        cur_en    = en_q[i];
        cur_supp  = supp[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output next-state: a dark digit (guard, disabled, suppressed) drives
  // everything off, decimal point included.
  // ---------------------------------------------------------------------------
  logic lit;

  always_comb begin
    lit      = !in_guard && cur_en && !cur_supp;
    seg_d    = SEG_OFF;
    dpo_d    = POL;
    an_d     = AN_OFF;
    strobe_d = cnt_wrap;
    if (lit) begin
      seg_d = seg_map(cur_nib) ^ SEG_OFF;
      dpo_d = cur_dp ^ POL;
      an_d  = an_sel ^ AN_OFF;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      en_q     <= '0;
      lzb_q    <= 1'b0;
      seg_q    <= SEG_OFF;
      dpo_q    <= POL;
      an_q     <= AN_OFF;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      lzb_q    <= lzb_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      an_q     <= an_d;
      strobe_q <= strobe_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dpo_q;
  assign an_out      = an_q;
  assign slot_strobe = strobe_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a common-anode multi-digit 7-segment display. It is the parametrised successor to the single-digit hex decoder. It captures a packed hex value into a shadow register and scans one digit per slot, with registered outputs. Per-digit enable, per-digit decimal point, leading-zero suppression and an anti-ghosting guard interval are included. It sits between the status/data datapath and the board display pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- SCAN_DIV, 100000: clock cycles per digit slot; must be at least 2.
- GUARD, 1000: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD < SCAN_DIV.
- ACTIVE_LOW, 1: 1 means segment, dp and anode outputs are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- value_in  in  4*NUM_DIGITS  packed hex nibbles; nibble i is bits [4i+3:4i]; digit 0 is least significant.
- load  in  1  captures value_in, dp_in, digit_en and lz_blank into the shadow registers on this edge.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 keeps that digit dark.
- lz_blank  in  1  leading-zero suppression enable.
- seg_out  out  7  segment drive; bit 6 = a … bit 0 = g.
- dp_out  out  1  decimal point drive.
- an_out  out  NUM_DIGITS  anode select, one-hot when lit, all off otherwise.
- slot_strobe  out  1  one-cycle pulse when the digit index advances.

## Operation
- Segment map, active-high form, bit 6 = a … bit 0 = g:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- When ACTIVE_LOW=1, seg_out, dp_out and an_out are bitwise inverted.
- "Off" means all segments, dp and anodes deasserted at the pin level: all ones when ACTIVE_LOW=1, all zeros when ACTIVE_LOW=0.
- Shadow registers (value, dp, en, lzb) are written only when load=1. Inputs are ignored otherwise.
- Scan counter cnt runs 0..SCAN_DIV-1 and wraps.
  - At cnt=SCAN_DIV-1, digit index idx advances modulo NUM_DIGITS: NUM_DIGITS-1 wraps to 0.
  - slot_strobe is asserted on that cycle.
- Digit lit condition: cnt ≥ GUARD, and en[idx]=1, and idx is not suppressed.
  - When lit, an_out selects idx, seg_out shows the map of nibble idx, and dp_out = dp[idx].
  - Otherwise everything is off, including dp.
- Leading-zero suppression: when lzb=1, digit i is suppressed if nibbles NUM_DIGITS-1 down to i are all zero.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- A disabled or suppressed digit still consumes its full slot. Refresh rate and brightness stay constant.
- NUM_DIGITS=1: idx stays 0 and slot_strobe pulses every SCAN_DIV cycles.

## Timing
- Reset state (async assert, applied immediately):
  - cnt=0, idx=0, all shadow registers 0.
  - seg_out, dp_out and an_out off; slot_strobe=0.
- Reset release: the first slot is idx 0, starting at cnt=0 on the first clock edge after deassertion.
- seg_out, dp_out, an_out and slot_strobe are registered. Each reflects cnt, idx and shadow state one cycle later.
- load latency: a value captured at edge t appears on the pins at edge t+1 if the current digit is lit.
- load during a lit slot changes the displayed digit mid-slot. This is allowed; no glitch filtering is applied.
- load and a slot wrap on the same edge: both take effect. The new idx is displayed with the new shadow contents.
- Reset asserted mid-slot: outputs go off asynchronously. Scanning restarts from idx 0 and the shadow contents are lost.

## Test plan
- Reset: hold rst with ACTIVE_LOW=1, NUM_DIGITS=4 → seg_out=7F, dp_out=1, an_out=F, slot_strobe=0.
- Basic scan: SCAN_DIV=4, GUARD=1, load value 0x1A3F with all digits enabled.
  - Required: slots show F, 3, A, 1 in order on an_out E, D, B, 7, with the F slot showing seg_out=~47.
  - Required: anodes are off on the first cycle of each slot, and slot_strobe pulses every 4 cycles.
- Leading-zero suppression: load 0x0070 with lzb=1 → digits 3 and 2 dark; digit 1 shows 7 and digit 0 shows 0.
  - Load 0x0000 with lzb=1 → only digit 0 lit, showing 0 (seg_out=~7E).
- Enable and dp: load dp_in=0101 and digit_en=1011 → digit 2 never lit.
  - Required: dp_out asserted only during digit 0 and digit 2 slots; since digit 2 is disabled, dp is seen only on digit 0.
- Load timing: load at the same edge as the idx 1→2 wrap → digit 2 shows the new nibble on the next cycle.
  - Required: a load with load=0 and changing value_in causes no output change.
- Mid-slot reset: assert rst at cnt=2 of idx 2 → outputs off immediately.
  - Required after release: scan resumes at idx 0 and the display is blank until the next load.
